// File: rtl/fm_addr_ctrl.sv
// Address and sequencing controller for the feature-map DRM.
// Runs LOAD (DDR->FM), CONV (3x3 window reads + result writes) and STORE (FM->DDR) phases.
module fm_addr_ctrl #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DIM_WIDTH  = 9,
  parameter int unsigned KSIZE      = 3
) (
  input  logic                  calc_clk,
  input  logic                  rstn,
  input  logic [2:0]            current_state,
  input  logic [ADDR_WIDTH-1:0] cfg_in_base,
  input  logic [ADDR_WIDTH-1:0] cfg_out_base,
  input  logic [DIM_WIDTH-1:0]  cfg_in_w,
  input  logic [DIM_WIDTH-1:0]  cfg_in_h,
  input  logic [ADDR_WIDTH-1:0] cfg_load_len,
  input  logic [ADDR_WIDTH-1:0] cfg_store_len,
  input  logic                  ddr_wr_valid,
  input  logic                  conv_wr_valid,
  input  logic                  rd_stall,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic                  rd_data_valid,
  output logic                  fm_DDR_wr,
  output logic                  state_rst
);

  localparam int unsigned CntWidth = 2 * DIM_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] AOne  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AK    = ADDR_WIDTH'(KSIZE);
  localparam logic [ADDR_WIDTH-1:0] AKm1  = ADDR_WIDTH'(KSIZE - 1);
  localparam logic [DIM_WIDTH-1:0]  DOne  = DIM_WIDTH'(1);
  localparam logic [DIM_WIDTH-1:0]  DK    = DIM_WIDTH'(KSIZE);
  localparam logic [DIM_WIDTH-1:0]  DKm1  = DIM_WIDTH'(KSIZE - 1);
  localparam logic [CntWidth-1:0]   COne  = CntWidth'(1);

  typedef enum logic [1:0] {PhIdle, PhLoad, PhConv, PhStore} phase_e;

  phase_e phase;
  logic   entry;

  logic [2:0]            prev_state_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] win_base_q, win_base_d, off_q, off_d;
  logic [ADDR_WIDTH-1:0] out_base_q, out_base_d, len_q, len_d, cnt_q, cnt_d;
  logic [DIM_WIDTH-1:0]  in_w_q, in_w_d, in_h_q, in_h_d;
  logic [DIM_WIDTH-1:0]  kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
  logic [CntWidth-1:0]   win_cnt_q, win_cnt_d, wr_cnt_q, wr_cnt_d;
  logic all_issued_q, all_issued_d, done_q, done_d, store_last_q, store_last_d;
  logic rd_valid_q, rd_valid_d, rd_data_valid_q, fm_ddr_wr_q, fm_ddr_wr_d;
  logic state_rst_q, state_rst_d;

  always_comb begin
    case (current_state)
      3'd1:    phase = PhLoad;
      3'd2:    phase = PhConv;
      3'd3:    phase = PhStore;
      default: phase = PhIdle;
    endcase
  end

  assign entry = (current_state != prev_state_q);

  always_comb begin
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    win_base_d   = win_base_q;
    off_d        = off_q;
    out_base_d   = out_base_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    in_w_d       = in_w_q;
    in_h_d       = in_h_q;
    kx_d         = kx_q;
    ky_d         = ky_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    win_cnt_d    = win_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    all_issued_d = all_issued_q;
    done_d       = done_q;
    store_last_d = 1'b0;
    rd_valid_d   = 1'b0;
    fm_ddr_wr_d  = 1'b0;
    state_rst_d  = 1'b0;

    if (entry) begin
      // Any change of phase restarts from the current configuration; a pending pulse is dropped.
      win_base_d   = cfg_in_base;
      off_d        = '0;
      out_base_d   = cfg_out_base;
      len_d        = (phase == PhStore) ? cfg_store_len : cfg_load_len;
      cnt_d        = '0;
      in_w_d       = cfg_in_w;
      in_h_d       = cfg_in_h;
      kx_d         = '0;
      ky_d         = '0;
      ox_d         = '0;
      oy_d         = '0;
      win_cnt_d    = '0;
      wr_cnt_d     = '0;
      all_issued_d = 1'b0;
      done_d       = 1'b0;
      if (phase == PhLoad) begin
        wr_addr_d   = cfg_in_base;
        fm_ddr_wr_d = 1'b1;
      end else if (phase == PhConv) begin
        wr_addr_d = cfg_out_base;
      end
    end else begin
      unique case (phase)
        PhLoad: begin
          fm_ddr_wr_d = 1'b1;
          if (ddr_wr_valid && !done_q) begin
            wr_addr_d = wr_addr_q + AOne;
            cnt_d     = cnt_q + AOne;
            if (cnt_q == len_q - AOne) begin
              done_d      = 1'b1;
              state_rst_d = 1'b1;
            end
          end
        end
        PhConv: begin
          if (!rd_stall && !all_issued_q) begin
            rd_addr_d  = win_base_q + off_q;
            rd_valid_d = 1'b1;
            if (kx_q != DKm1) begin
              kx_d  = kx_q + DOne;
              off_d = off_q + AOne;
            end else if (ky_q != DKm1) begin
              kx_d  = '0;
              ky_d  = ky_q + DOne;
              off_d = off_q + ADDR_WIDTH'(in_w_q) - AKm1;
            end else begin
              kx_d      = '0;
              ky_d      = '0;
              off_d     = '0;
              win_cnt_d = win_cnt_q + COne;
              if (ox_q != in_w_q - DK) begin
                ox_d       = ox_q + DOne;
                win_base_d = win_base_q + AOne;
              end else begin
                // Last column of a row: step from (row, in_w-K) to (row+1, 0).
                ox_d       = '0;
                win_base_d = win_base_q + AK;
                if (oy_q == in_h_q - DK) all_issued_d = 1'b1;
                else                     oy_d = oy_q + DOne;
              end
            end
          end
          if (conv_wr_valid && !done_q) begin
            wr_addr_d = wr_addr_q + AOne;
            wr_cnt_d  = wr_cnt_q + COne;
          end
          if (!done_q && all_issued_d && (wr_cnt_d == win_cnt_d)) begin
            done_d      = 1'b1;
            state_rst_d = 1'b1;
          end
        end
        PhStore: begin
          if (!rd_stall && !done_q) begin
            rd_addr_d  = out_base_q + cnt_q;
            rd_valid_d = 1'b1;
            cnt_d      = cnt_q + AOne;
            if (cnt_q == len_q - AOne) begin
              done_d       = 1'b1;
              store_last_d = 1'b1;
            end
          end
          // Pulse in the cycle after the last read is presented.
          state_rst_d = store_last_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge calc_clk or negedge rstn) begin
    if (!rstn) begin
      prev_state_q    <= '0;
      wr_addr_q       <= '0;
      rd_addr_q       <= '0;
      win_base_q      <= '0;
      off_q           <= '0;
      out_base_q      <= '0;
      len_q           <= '0;
      cnt_q           <= '0;
      in_w_q          <= '0;
      in_h_q          <= '0;
      kx_q            <= '0;
      ky_q            <= '0;
      ox_q            <= '0;
      oy_q            <= '0;
      win_cnt_q       <= '0;
      wr_cnt_q        <= '0;
      all_issued_q    <= 1'b0;
      done_q          <= 1'b0;
      store_last_q    <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_data_valid_q <= 1'b0;
      fm_ddr_wr_q     <= 1'b0;
      state_rst_q     <= 1'b0;
    end else begin
      prev_state_q    <= current_state;
      wr_addr_q       <= wr_addr_d;
      rd_addr_q       <= rd_addr_d;
      win_base_q      <= win_base_d;
      off_q           <= off_d;
      out_base_q      <= out_base_d;
      len_q           <= len_d;
      cnt_q           <= cnt_d;
      in_w_q          <= in_w_d;
      in_h_q          <= in_h_d;
      kx_q            <= kx_d;
      ky_q            <= ky_d;
      ox_q            <= ox_d;
      oy_q            <= oy_d;
      win_cnt_q       <= win_cnt_d;
      wr_cnt_q        <= wr_cnt_d;
      all_issued_q    <= all_issued_d;
      done_q          <= done_d;
      store_last_q    <= store_last_d;
      rd_valid_q      <= rd_valid_d;
      rd_data_valid_q <= rd_valid_q;
      fm_ddr_wr_q     <= fm_ddr_wr_d;
      state_rst_q     <= state_rst_d;
    end
  end

  assign wr_addr       = wr_addr_q;
  assign rd_addr       = rd_addr_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data_valid = rd_data_valid_q;
  assign fm_DDR_wr     = fm_ddr_wr_q;
  assign state_rst     = state_rst_q;

endmodule

// File: tb/tb_fm_addr_ctrl.sv
// Directed bench for fm_addr_ctrl: LOAD, CONV (with and without stall), STORE wrap,
// reset mid-LOAD and LOAD->STORE abort.
module tb_fm_addr_ctrl;
  localparam int unsigned AW = 13;
  localparam int unsigned DW = 9;

  logic          calc_clk = 1'b0;
  logic          rstn;
  logic [2:0]    current_state;
  logic [AW-1:0] cfg_in_base, cfg_out_base, cfg_load_len, cfg_store_len;
  logic [DW-1:0] cfg_in_w, cfg_in_h;
  logic          ddr_wr_valid, conv_wr_valid, rd_stall;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          rd_valid, rd_data_valid, fm_DDR_wr, state_rst;

  int checks = 0;
  int errors = 0;

  fm_addr_ctrl #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW), .KSIZE(3)) dut (
    .calc_clk      (calc_clk),
    .rstn          (rstn),
    .current_state (current_state),
    .cfg_in_base   (cfg_in_base),
    .cfg_out_base  (cfg_out_base),
    .cfg_in_w      (cfg_in_w),
    .cfg_in_h      (cfg_in_h),
    .cfg_load_len  (cfg_load_len),
    .cfg_store_len (cfg_store_len),
    .ddr_wr_valid  (ddr_wr_valid),
    .conv_wr_valid (conv_wr_valid),
    .rd_stall      (rd_stall),
    .wr_addr       (wr_addr),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_data_valid (rd_data_valid),
    .fm_DDR_wr     (fm_DDR_wr),
    .state_rst     (state_rst)
  );

  always #5 calc_clk = ~calc_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge calc_clk);
    #1;
  endtask

  // CONV on a 5x4 map from base 100, results to 500; stall for nstall cycles from stall_at.
  task automatic conv_run(input int stall_at, input int nstall);
    int          exp_addr[54];
    int          hand[10];
    int          idx, n, wrs, last_w;
    logic        exp_rv, rv_prev, stall_prev;
    hand = '{100, 101, 102, 105, 106, 107, 110, 111, 112, 101};
    idx = 0;
    for (int oy = 0; oy < 2; oy++)
      for (int ox = 0; ox < 3; ox++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++) begin
            exp_addr[idx] = 100 + (oy + ky) * 5 + ox + kx;
            idx++;
          end
    cfg_in_base = 100; cfg_in_w = 5; cfg_in_h = 4; cfg_out_base = 500;
    rd_stall = 0; conv_wr_valid = 0;
    current_state = 3'd2;
    cyc();
    chk("conv_entry_rv", {31'd0, rd_valid}, 0);
    chk("conv_entry_wa", {19'd0, wr_addr}, 500);
    last_w = 57 + nstall;
    n = 0; wrs = 0; rv_prev = 0; stall_prev = 0;
    for (int c = 2; c <= last_w + 2; c++) begin
      cyc();
      exp_rv = !stall_prev && (n < 54);
      chk("conv_rv", {31'd0, rd_valid}, {31'd0, exp_rv});
      chk("conv_rdv", {31'd0, rd_data_valid}, {31'd0, rv_prev});
      if (exp_rv) begin
        chk("conv_rd_addr", {19'd0, rd_addr}, exp_addr[n]);
        if (n < 10) chk("conv_rd_first10", {19'd0, rd_addr}, hand[n]);
        if (n == 53) chk("conv_rd_last", {19'd0, rd_addr}, 119);
        n++;
      end else if (n > 0) begin
        chk("conv_rd_hold", {19'd0, rd_addr}, exp_addr[n-1]);
      end
      chk("conv_wr_addr", {19'd0, wr_addr}, 500 + wrs);
      chk("conv_state_rst", {31'd0, state_rst}, (c == last_w + 1) ? 1 : 0);
      chk("conv_fm", {31'd0, fm_DDR_wr}, 0);
      rv_prev = exp_rv;
      rd_stall = (c >= stall_at) && (c < stall_at + nstall);
      conv_wr_valid = (c == 12) || (c == 20) || (c == 30) || (c == 40) || (c == 50) ||
                      (c == last_w);
      if (conv_wr_valid) wrs++;
      stall_prev = rd_stall;
    end
    rd_stall = 0; conv_wr_valid = 0;
  endtask

  task automatic go_idle();
    current_state = 3'd0;
    cyc();
    chk("idle_fm", {31'd0, fm_DDR_wr}, 0);
    chk("idle_rv", {31'd0, rd_valid}, 0);
  endtask

  initial begin
    rstn = 0; current_state = 0;
    cfg_in_base = 0; cfg_out_base = 0; cfg_in_w = 0; cfg_in_h = 0;
    cfg_load_len = 0; cfg_store_len = 0;
    ddr_wr_valid = 0; conv_wr_valid = 0; rd_stall = 0;
    cyc(); cyc();
    chk("rst_wa", {19'd0, wr_addr}, 0);
    chk("rst_ra", {19'd0, rd_addr}, 0);
    chk("rst_rv", {31'd0, rd_valid}, 0);
    chk("rst_rdv", {31'd0, rd_data_valid}, 0);
    chk("rst_fm", {31'd0, fm_DDR_wr}, 0);
    chk("rst_st", {31'd0, state_rst}, 0);
    rstn = 1;
    cyc();

    // LOAD base 100, len 4, strobes on cycles 2,3,5,6
    cfg_in_base = 100; cfg_load_len = 4; current_state = 3'd1;
    cyc();
    chk("load_fm_c1", {31'd0, fm_DDR_wr}, 1);
    chk("load_wa_c1", {19'd0, wr_addr}, 100);
    cyc(); ddr_wr_valid = 1; chk("load_wa_c2", {19'd0, wr_addr}, 100);
    cyc(); ddr_wr_valid = 1; chk("load_wa_c3", {19'd0, wr_addr}, 101);
    cyc(); ddr_wr_valid = 0; chk("load_wa_c4", {19'd0, wr_addr}, 102);
    chk("load_st_c4", {31'd0, state_rst}, 0);
    cyc(); ddr_wr_valid = 1; chk("load_wa_c5", {19'd0, wr_addr}, 102);
    cyc(); ddr_wr_valid = 1; chk("load_wa_c6", {19'd0, wr_addr}, 103);
    chk("load_st_c6", {31'd0, state_rst}, 0);
    cyc(); ddr_wr_valid = 0; chk("load_st_c7", {31'd0, state_rst}, 1);
    chk("load_wa_c7", {19'd0, wr_addr}, 104);
    cyc(); ddr_wr_valid = 1; chk("load_st_c8", {31'd0, state_rst}, 0);
    cyc(); ddr_wr_valid = 0; chk("load_wa_after_done", {19'd0, wr_addr}, 104);
    chk("load_st_c9", {31'd0, state_rst}, 0);
    chk("load_fm_c9", {31'd0, fm_DDR_wr}, 1);
    go_idle();
    chk("idle_wa_hold", {19'd0, wr_addr}, 104);

    conv_run(0, 0);
    go_idle();
    conv_run(6, 3);
    go_idle();

    // STORE from 8190, len 4: wraps through 0
    cfg_out_base = 8190; cfg_store_len = 4; current_state = 3'd3;
    cyc(); chk("store_rv_c1", {31'd0, rd_valid}, 0);
    cyc(); chk("store_rv_c2", {31'd0, rd_valid}, 1); chk("store_ra_c2", {19'd0, rd_addr}, 8190);
    cyc(); chk("store_ra_c3", {19'd0, rd_addr}, 8191);
    cyc(); chk("store_ra_c4", {19'd0, rd_addr}, 0);
    cyc(); chk("store_ra_c5", {19'd0, rd_addr}, 1); chk("store_st_c5", {31'd0, state_rst}, 0);
    cyc(); chk("store_st_c6", {31'd0, state_rst}, 1); chk("store_rv_c6", {31'd0, rd_valid}, 0);
    chk("store_rdv_c6", {31'd0, rd_data_valid}, 1);
    cyc(); chk("store_st_c7", {31'd0, state_rst}, 0);
    go_idle();

    // Reset mid-LOAD after two writes
    cfg_in_base = 200; cfg_load_len = 4; current_state = 3'd1;
    cyc(); chk("rload_wa_c1", {19'd0, wr_addr}, 200); ddr_wr_valid = 1;
    cyc(); chk("rload_wa_c2", {19'd0, wr_addr}, 201);
    cyc(); chk("rload_wa_c3", {19'd0, wr_addr}, 202); ddr_wr_valid = 0;
    rstn = 0;
    #1;
    chk("rload_async_wa", {19'd0, wr_addr}, 0);
    chk("rload_async_fm", {31'd0, fm_DDR_wr}, 0);
    chk("rload_async_st", {31'd0, state_rst}, 0);
    cyc(); chk("rload_hold_st", {31'd0, state_rst}, 0);
    rstn = 1;
    cyc(); chk("rload_restart_wa", {19'd0, wr_addr}, 200);
    chk("rload_restart_fm", {31'd0, fm_DDR_wr}, 1);
    chk("rload_restart_st", {31'd0, state_rst}, 0);
    ddr_wr_valid = 1;
    cyc(); chk("rload_wa_next", {19'd0, wr_addr}, 201); ddr_wr_valid = 0;

    // Abort LOAD by switching to STORE
    cfg_out_base = 300; cfg_store_len = 2; current_state = 3'd3;
    cyc(); chk("abort_fm", {31'd0, fm_DDR_wr}, 0); chk("abort_st", {31'd0, state_rst}, 0);
    chk("abort_rv", {31'd0, rd_valid}, 0);
    cyc(); chk("abort_ra0", {19'd0, rd_addr}, 300); chk("abort_st1", {31'd0, state_rst}, 0);
    cyc(); chk("abort_ra1", {19'd0, rd_addr}, 301); chk("abort_st2", {31'd0, state_rst}, 0);
    cyc(); chk("abort_store_done", {31'd0, state_rst}, 1);
    cyc(); chk("abort_st_once", {31'd0, state_rst}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
